// File: rtl/ic_fetch_queue.sv
// IF->ID fetch queue: DEPTH-entry circular FIFO of fetch bundles with valid/ready
// on both sides; a taken branch on br_bus flushes everything buffered.
module ic_fetch_queue #(
  parameter int DATA_WD  = 65,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [32:0]                br_bus,
  input  logic                       in_valid,
  input  logic [DATA_WD-1:0]         in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DATA_WD-1:0]         out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [PW-1:0] AF_THRESH = PW'(AF_LEVEL);

  logic [DATA_WD-1:0] mem_q [DEPTH];
  logic [PW-1:0]      rdPtr_q, rdPtr_d;
  logic [PW-1:0]      wrPtr_q, wrPtr_d;
  logic [PW-1:0]      count_d;
  logic               almostFull_q;
  logic               brE;
  logic               isEmpty;
  logic               isFull;
  logic               doPush;
  logic               doPop;
  logic               unused_br_addr;

  assign brE            = br_bus[32];
  assign unused_br_addr = ^br_bus[31:0];

  // The wrap bit is the only thing telling full apart from empty.
  assign isEmpty = (rdPtr_q == wrPtr_q);
  assign isFull  = (rdPtr_q[AW-1:0] == wrPtr_q[AW-1:0]) && (rdPtr_q[AW] != wrPtr_q[AW]);

  assign in_ready  = !isFull;
  assign out_valid = !isEmpty;
  assign out_data  = isEmpty ? '0 : mem_q[rdPtr_q[AW-1:0]];
  assign count     = wrPtr_q - rdPtr_q;
  assign almost_full = almostFull_q;

  assign doPush = in_valid && !isFull && !brE;
  assign doPop  = !isEmpty && out_ready && !brE;

  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    if (brE) begin
      rdPtr_d = wrPtr_q;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + PTR_ONE;
      if (doPop)  rdPtr_d = rdPtr_q + PTR_ONE;
    end
    count_d = wrPtr_d - rdPtr_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr_q      <= '0;
      wrPtr_q      <= '0;
      almostFull_q <= 1'b0;
    end else begin
      rdPtr_q      <= rdPtr_d;
      wrPtr_q      <= wrPtr_d;
      almostFull_q <= (count_d >= AF_THRESH);
    end
  end

  // Storage is never cleared; out_data masking hides stale entries.
  always_ff @(posedge clk) begin
    if (!rst && doPush) mem_q[wrPtr_q[AW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_ic_fetch_queue.sv
// Directed + random bench for ic_fetch_queue; a queue of expected bundles is
// pushed on accepted input and popped/compared when ID consumes the head.
module tb_ic_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [32:0] br_bus;
  logic        in_valid;
  logic [64:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [64:0] out_data;
  logic        out_ready;
  logic [2:0]  count;
  logic        almost_full;

  int checks = 0;
  int passed = 0;
  logic [64:0] model[$];

  ic_fetch_queue #(.DATA_WD(65), .DEPTH(4), .AF_LEVEL(3)) dut (
    .clk(clk), .rst(rst), .br_bus(br_bus),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drive one cycle, check outputs against the model, clock, then update the model.
  task automatic applyStimulus(input logic iv, input logic [64:0] d, input logic ordy,
                               input logic br, input logic rs);
    int sz;
    logic expFull;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    br_bus    = {br, $urandom()};
    rst       = rs;
    #1;
    sz      = model.size();
    expFull = (sz == 4);
    checkOutput("out_valid", {64'd0, out_valid}, {64'd0, sz != 0});
    checkOutput("out_data", out_data, (sz != 0) ? model[0] : 65'd0);
    checkOutput("in_ready", {64'd0, in_ready}, {64'd0, !expFull});
    checkOutput("count", {62'd0, count}, 65'(sz));
    checkOutput("almost_full", {64'd0, almost_full}, {64'd0, sz >= 3});
    @(posedge clk);
    #1;
    if (rs || br) begin
      model.delete();
    end else begin
      if (ordy && sz != 0) void'(model.pop_front());
      if (iv && !expFull) model.push_back(d);
    end
  endtask

  initial begin
    rst = 1'b1; br_bus = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_count", {62'd0, count}, 65'd0);
    checkOutput("reset_in_ready", {64'd0, in_ready}, 65'd1);
    checkOutput("reset_out_data", out_data, 65'd0);

    // Three pushes with ID stalled, then drain.
    applyStimulus(1, 65'h11, 0, 0, 0);
    applyStimulus(1, 65'h22, 0, 0, 0);
    applyStimulus(1, 65'h33, 0, 0, 0);
    checkOutput("three_count", {62'd0, count}, 65'd3);
    checkOutput("three_af", {64'd0, almost_full}, 65'd1);
    repeat (4) applyStimulus(0, 65'h0, 1, 0, 0);

    // Fill, hold 0x55 while full, pop one, 0x55 enters last.
    for (int i = 1; i <= 4; i++) applyStimulus(1, 65'(i * 16 + 4), 0, 0, 0);
    repeat (3) applyStimulus(1, 65'h55, 0, 0, 0);
    checkOutput("full_in_ready", {64'd0, in_ready}, 65'd0);
    applyStimulus(1, 65'h55, 1, 0, 0);
    applyStimulus(1, 65'h55, 0, 0, 0);
    checkOutput("after_pop_count", {62'd0, count}, 65'd4);
    repeat (5) applyStimulus(0, 65'h0, 1, 0, 0);

    // Streaming across several pointer wraps.
    for (int i = 1; i <= 20; i++) applyStimulus(1, 65'(i), 1, 0, 0);
    checkOutput("stream_count", {62'd0, count}, 65'd1);
    applyStimulus(0, 65'h0, 1, 0, 0);

    // Flush with push and pop requested in the same cycle.
    for (int i = 0; i < 3; i++) applyStimulus(1, 65'(8'hA0 + i), 0, 0, 0);
    applyStimulus(1, 65'h99, 1, 1, 0);
    checkOutput("flush_count", {62'd0, count}, 65'd0);
    checkOutput("flush_valid", {64'd0, out_valid}, 65'd0);
    checkOutput("flush_data", out_data, 65'd0);
    repeat (2) applyStimulus(0, 65'h0, 1, 0, 0);

    // Reset mid-stream with a push pending.
    applyStimulus(1, 65'hB1, 0, 0, 0);
    applyStimulus(1, 65'hB2, 0, 0, 0);
    applyStimulus(1, 65'hB3, 0, 0, 1);
    checkOutput("rst_count", {62'd0, count}, 65'd0);
    checkOutput("rst_in_ready", {64'd0, in_ready}, 65'd1);
    applyStimulus(0, 65'h0, 1, 0, 0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(1'($urandom_range(1)), {1'b0, $urandom(), $urandom()},
                    1'($urandom_range(1)), $urandom_range(99) < 5, 0);
      checks++;
      assert (count <= 3'd4) passed++;
      else $error("FAIL count_bound observed=%0d expected<=4", count);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ic_fetch_queue.md
Name: ic_fetch_queue

Overview:
- Parametrised successor to the single-entry IF->ID (IC) pipeline register. Replaces it with a DEPTH-entry FIFO of fetch bundles between IF and ID.
- Uses a valid/ready handshake on both sides in place of the stall-bus bubble insertion.
- A branch redirect on br_bus flushes every buffered bundle.
- Decouples fetch from decode stalls without losing or duplicating instructions.

Parameters:
- DATA_WD, 65: width of one fetch bundle (pc + inst + flags), opaque to this block.
- DEPTH, 4: number of entries. Power of two, at least 2.
- AF_LEVEL, 3: occupancy at or above which almost_full asserts. Range 1..DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- br_bus  in  33  {br_e, br_addr[31:0]}. Only br_e is used; br_addr is ignored.
- in_valid  in  1  IF presents a bundle.
- in_data  in  DATA_WD  bundle from IF.
- in_ready  out  1  queue can accept a bundle this cycle.
- out_valid  out  1  head bundle is valid for ID.
- out_data  out  DATA_WD  head bundle.
- out_ready  in  1  ID consumes the head this cycle.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  out  1  count >= AF_LEVEL.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Storage:
  - Circular buffer of DEPTH entries.
  - rd_ptr and wr_ptr are $clog2(DEPTH)+1 bits wide. The MSB is a wrap bit.
  - empty = (rd_ptr == wr_ptr).
  - full = (index bits equal) and (wrap bits differ).
  - count = wr_ptr - rd_ptr, modulo 2^(ptr width).
- Reset:
  - Pointers go to 0. count = 0, out_valid = 0, in_ready = 1, almost_full = 0.
  - out_data is all-zero while empty, both at reset and after a flush.
  - Stored data is not cleared.
- Push: occurs when in_valid & in_ready & !br_e. Writes in_data to mem[wr_ptr], then wr_ptr++.
- Pop: occurs when out_valid & out_ready & !br_e. Advances rd_ptr++.
- in_ready = !full. It has no combinational dependence on out_ready, so a full queue accepts nothing even when it is popped in the same cycle.
- out_valid = !empty. out_data = mem[rd_ptr index], read combinationally from the registered array and forced to 0 when empty.
- Latency: a bundle pushed at edge N is visible on out_data after edge N, i.e. one cycle. There is no same-cycle bypass.
- Simultaneous push and pop (not full, not empty): both pointers advance and count is unchanged.
- Empty queue: a push in the same cycle cannot pop, because out_valid = 0.
- Flush (br_e = 1 at an edge):
  - rd_ptr <= wr_ptr, so the queue becomes empty.
  - Any push or pop requested in that cycle is discarded.
  - The next cycle shows out_valid = 0 and count = 0.
  - br_e overrides everything except rst.
- Priority: rst > br_e > push/pop.
- Wrap-around: the pointers wrap naturally and data order is preserved across the wrap. Full and empty are distinguished only by the wrap bit.
- Protocol assumption on the IF side: IF holds in_valid/in_data stable until accepted, but the queue does not rely on this.
- Illegal cases, which are never reached by construction: overflow (push when full) and underflow (pop when empty). Both are blocked by in_ready and out_valid.
- almost_full: a registered compare of the post-update count against AF_LEVEL. IF uses it for prefetch throttling.

Test Plan:
- Reset, then push bundles 0x11, 0x22, 0x33 with out_ready = 0:
  - count = 3 and almost_full = 1 (AF_LEVEL = 3).
  - Then out_ready = 1: outputs 0x11, 0x22, 0x33 on consecutive cycles, then out_valid = 0.
- Fill to DEPTH = 4, then hold in_valid = 1 with 0x55:
  - in_ready = 0, count stays 4.
  - Pop one: the next cycle in_ready = 1 and 0x55 is accepted as the 5th bundle, exiting last.
- Steady streaming with push and pop every cycle for 20 cycles, values 1..20:
  - count stays at 1 after warm-up.
  - Output sequence is 1..20 in order, covering multiple pointer wraps.
- With 3 entries queued, assert br_e together with in_valid (0x99) and out_ready:
  - Next cycle: count = 0, out_valid = 0, out_data = 0.
  - 0x99 is never output, and no queued bundle is output.
- Assert rst for one edge with 2 entries queued and in_valid = 1: next cycle count = 0, out_valid = 0, in_ready = 1, and no bundle is lost to a spurious output.
- Random in_valid/out_ready at 50% each, plus br_e at 5%, over 10k cycles:
  - A scoreboard matches output order.
  - Flushed bundles are dropped.
  - count never exceeds 4.
